// File: rtl/count_ssd_driver.sv
// count_ssd_driver: up/down counter with sequential BCD conversion driving a 4-digit multiplexed seven-segment display
//   clk, rst (async, active-high), slow_clk (tick source), en (count enable), up (direction)
//   count (current value), an (active-low anodes, bit 0 rightmost), seg ({g..a} active-low), dp (off), bcd_busy
module count_ssd_driver #(
  parameter int REFRESH_DIV = 100_000,
  parameter bit HEX_MODE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slow_clk,
  input  logic       en,
  input  logic       up,
  output logic [7:0] count,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       bcd_busy
);
  localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic slow_q, tick;
  logic [7:0] count_q, count_d, src_q, src_d, bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] dig0_q, dig0_d, dig1_q, dig1_d, dig2_q, dig2_d, cur;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic wrap, blank;
  function automatic logic [3:0] adj(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction
  assign tick = slow_clk & ~slow_q;
  assign count_d = (tick && en) ? (up ? count_q + 8'd1 : count_q - 8'd1) : count_q;
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    bit_cnt_d = bit_cnt_q;
    dig0_d = dig0_q;
    dig1_d = dig1_q;
    dig2_d = dig2_q;
    if (HEX_MODE) begin
      dig0_d = count_q[3:0];
      dig1_d = count_q[7:4];
      dig2_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: if (count_q != src_q) begin
          src_d = count_q;
          bin_d = count_q;
          bcd_d = '0;
          bit_cnt_d = '0;
          state_d = SHIFT;
        end
        SHIFT: begin
          {bcd_d, bin_d} = {adj(bcd_q[11:8]), adj(bcd_q[7:4]), adj(bcd_q[3:0]), bin_q} << 1;
          bit_cnt_d = bit_cnt_q + 4'd1;
          state_d = bit_cnt_q == 4'd7 ? DONE : SHIFT;
        end
        DONE: begin
          dig2_d = bcd_q[11:8];
          dig1_d = bcd_q[7:4];
          dig0_d = bcd_q[3:0];
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign wrap = rcnt_q == RW'(REFRESH_DIV - 1);
  assign rcnt_d = wrap ? '0 : rcnt_q + RW'(1);
  assign sel_d = wrap ? sel_q + 2'd1 : sel_q;
  assign cur = sel_q == 2'd0 ? dig0_q : sel_q == 2'd1 ? dig1_q : sel_q == 2'd2 ? dig2_q : 4'd0;
  // Leading-zero blanking: tens only blank when hundreds is blank too
  assign blank = sel_q == 2'd3
              || (sel_q == 2'd2 && (HEX_MODE || dig2_q == 4'd0))
              || (sel_q == 2'd1 && !HEX_MODE && dig2_q == 4'd0 && dig1_q == 4'd0);
  assign an_d = blank ? 4'hF : ~(4'b0001 << sel_q);
  assign seg_d = decode(cur);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slow_q <= 1'b0;
      count_q <= '0;
      state_q <= IDLE;
      src_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
      bit_cnt_q <= '0;
      dig0_q <= '0;
      dig1_q <= '0;
      dig2_q <= '0;
      rcnt_q <= '0;
      sel_q <= '0;
      an_q <= 4'b1110;
      seg_q <= 7'b1000000;
    end else begin
      slow_q <= slow_clk;
      count_q <= count_d;
      state_q <= state_d;
      src_q <= src_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      dig0_q <= dig0_d;
      dig1_q <= dig1_d;
      dig2_q <= dig2_d;
      rcnt_q <= rcnt_d;
      sel_q <= sel_d;
      an_q <= an_d;
      seg_q <= seg_d;
    end
  end
  assign count = count_q;
  assign an = an_q;
  assign seg = seg_q;
  assign dp = 1'b1;
  assign bcd_busy = !HEX_MODE && state_q != IDLE;
endmodule

// File: tb/tb_count_ssd_driver.sv
// tb_count_ssd_driver: randomized check of decimal and hex display drivers against a behavioural model
module tb_count_ssd_driver;
  localparam int D = 4;
  logic clk = 1'b0, rst = 1'b0, slow_clk = 1'b0, en = 1'b0, up = 1'b1;
  logic [7:0] count_d, count_h;
  logic [3:0] an_d, an_h;
  logic [6:0] seg_d, seg_h;
  logic dp_d, dp_h, busy_d, busy_h;
  int checks = 0, failures = 0;
  count_ssd_driver #(.REFRESH_DIV(D), .HEX_MODE(1'b0)) dut_dec (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .en(en), .up(up),
    .count(count_d), .an(an_d), .seg(seg_d), .dp(dp_d), .bcd_busy(busy_d));
  count_ssd_driver #(.REFRESH_DIV(D), .HEX_MODE(1'b1)) dut_hex (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .en(en), .up(up),
    .count(count_h), .an(an_h), .seg(seg_h), .dp(dp_h), .bcd_busy(busy_h));
  always #5 clk = ~clk;
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // What a slot must show for a given displayed value: {anodes, segments}
  function automatic logic [10:0] view(input logic [7:0] v, input bit hex, input int sel);
    int h, t, o, dig;
    bit blank;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    if (hex) begin
      dig = sel == 0 ? v % 16 : v / 16;
      blank = sel >= 2;
    end else begin
      dig = sel == 0 ? o : sel == 1 ? t : h;
      blank = sel == 3 || (sel == 2 && h == 0) || (sel == 1 && h == 0 && t == 0);
    end
    return {blank ? 4'hF : ~(4'b0001 << sel), seg_tab[dig]};
  endfunction
  logic m_slow;
  logic [7:0] m_count, m_src, m_dec, m_hex;
  int m_rem, m_cyc;
  logic [3:0] m_an_d, m_an_h;
  logic [6:0] m_seg_d, m_seg_h;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_slow <= 1'b0;
      m_count <= '0;
      m_src <= '0;
      m_dec <= '0;
      m_hex <= '0;
      m_rem <= 0;
      m_cyc <= 0;
      {m_an_d, m_seg_d} <= view(8'd0, 1'b0, 0);
      {m_an_h, m_seg_h} <= view(8'd0, 1'b1, 0);
    end else begin
      m_slow <= slow_clk;
      if (slow_clk && !m_slow && en) m_count <= up ? m_count + 8'd1 : m_count - 8'd1;
      m_hex <= m_count;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_dec <= m_src;
      end else if (m_count != m_src) begin
        m_src <= m_count;
        m_rem <= 9;
      end
      m_cyc <= m_cyc + 1;
      {m_an_d, m_seg_d} <= view(m_dec, 1'b0, (m_cyc / D) % 4);
      {m_an_h, m_seg_h} <= view(m_hex, 1'b1, (m_cyc / D) % 4);
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("count_dec", count_d, m_count);
      chk("count_hex", count_h, m_count);
      chk("busy_dec", busy_d, m_rem > 0);
      chk("busy_hex", busy_h, 0);
      chk("an_dec", an_d, m_an_d);
      chk("an_hex", an_h, m_an_h);
      if (m_an_d != 4'hF) chk("seg_dec", seg_d, m_seg_d);
      if (m_an_h != 4'hF) chk("seg_hex", seg_h, m_seg_h);
      chk("dp_dec", dp_d, 1);
      chk("dp_hex", dp_h, 1);
    end
  end
  task automatic pulse(input int h, input int l);
    slow_clk = 1'b1;
    repeat (h) @(negedge clk);
    slow_clk = 1'b0;
    repeat (l) @(negedge clk);
  endtask
  task automatic goto(input logic [7:0] v);
    logic [7:0] diff;
    diff = v - m_count;
    en = 1'b1;
    up = diff <= 8'd128;
    while (m_count != v) pulse(1, 1);
  endtask
  task automatic wait_slot(input bit hex, input logic [3:0] want);
    int n;
    logic [3:0] prev;
    n = 0;
    prev = hex ? an_h : an_d;
    @(negedge clk);
    while (!((hex ? an_h : an_d) == want && prev != want) && n < 64) begin
      prev = hex ? an_h : an_d;
      @(negedge clk);
      n++;
    end
    if (n >= 64) chk("slot_timeout", hex ? an_h : an_d, want);
  endtask
  logic [3:0] ea [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
  logic [6:0] es [3] = '{7'b0110000, 7'b0100100, 7'b1111001};
  initial begin
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_count", count_d, 0);
    chk("rst_an", an_d, 4'b1110);
    chk("rst_seg", seg_d, 7'b1000000);
    chk("rst_busy", busy_d, 0);
    chk("rst_dp", dp_d, 1);
    rst = 1'b0;
    en = 1'b1;
    up = 1'b1;
    repeat (5) pulse(1, 3);
    chk("up5_count", count_d, 5);
    repeat (11) @(negedge clk);
    wait_slot(1'b0, 4'b1110);
    chk("up5_seg0", seg_d, 7'b0010010);
    goto(8'd255);
    repeat (12) @(negedge clk);
    up = 1'b1;
    pulse(1, 2);
    chk("wrap_up", count_d, 0);
    up = 1'b0;
    pulse(1, 12);
    chk("wrap_down", count_d, 255);
    wait_slot(1'b0, 4'b1011);
    chk("wrap_hund", seg_d, 7'b0100100);
    up = 1'b1;
    pulse(10, 2);
    chk("hold_high", count_d, 0);
    repeat (12) @(negedge clk);
    en = 1'b0;
    repeat (3) pulse(1, 2);
    chk("en_gate_count", count_d, 0);
    chk("en_gate_busy", busy_d, 0);
    goto(8'd200);
    repeat (3) @(negedge clk);
    chk("mid_conv_busy", busy_d, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_count", count_d, 0);
    chk("rst2_an", an_d, 4'b1110);
    chk("rst2_seg", seg_d, 7'b1000000);
    chk("rst2_busy", busy_d, 0);
    chk("rst2_dp", dp_d, 1);
    rst = 1'b0;
    @(negedge clk);
    goto(8'd123);
    repeat (12) @(negedge clk);
    wait_slot(1'b0, 4'b1110);
    for (int i = 0; i < 16; i++) begin
      chk("order_an", an_d, ea[i / 4]);
      if (i < 12) chk("order_seg", seg_d, es[i / 4]);
      @(negedge clk);
    end
    goto(8'hAB);
    repeat (2) @(negedge clk);
    wait_slot(1'b1, 4'b1110);
    chk("hex_dig0", seg_h, 7'b0000011);
    wait_slot(1'b1, 4'b1101);
    chk("hex_dig1", seg_h, 7'b0001000);
    for (int i = 0; i < 400; i++) begin
      en = $urandom_range(0, 3) != 0;
      up = $urandom_range(0, 1) == 1;
      pulse($urandom_range(1, 4), ($urandom % 8 == 0) ? $urandom_range(10, 40) : $urandom_range(1, 6));
    end
    repeat (30) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/count_ssd_driver.md
# count_ssd_driver

Consumes the `slow_clk` tick produced by the clock divider and does three things. It maintains the 8-bit up/down count, converts that count to BCD with a sequential double-dabble engine, and drives a 4-digit multiplexed common-anode seven-segment display. It sits directly downstream of the clock divider and directly upstream of the board pins, with everything in the single `clk` domain.

## Interface
- `REFRESH_DIV`, default 100_000: `clk` cycles per digit slot (1 kHz per digit at 100 MHz).
- `HEX_MODE`, default 0: 0 shows decimal with leading-zero blanking; 1 shows two hex digits.

- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `slow_clk` in 1: divider output; registered in `clk` domain, so no synchronizer is needed.
- `en` in 1: count enable.
- `up` in 1: 1 = increment, 0 = decrement.
- `count` out 8: current count value.
- `an` out 4: digit anodes, active-low; bit 0 is the rightmost digit.
- `seg` out 7: {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, constant 1 (off).
- `bcd_busy` out 1: high while a conversion is in flight.

## Operation
- **Edge detect:** `slow_q` <= `slow_clk`; `tick` = `slow_clk` & ~`slow_q`. Exactly one tick per `slow_clk` rising edge, however long `slow_clk` stays high.
- **Counter:** on `tick` & `en`, `count` <= `up` ? `count`+1 : `count`−1, mod 256 (255→0, 0→255). With `en`=0, ticks are ignored.
- **Converter FSM (HEX_MODE=0):** states IDLE, SHIFT, DONE.
  - IDLE: if `count` != `src`, latch `src` <= `count`, clear the 12-bit BCD scratch, set `bit_cnt` = 0, go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. After 8 shifts go to DONE.
  - DONE: commit hundreds/tens/ones to the `dig2`/`dig1`/`dig0` registers, return to IDLE.
  - `bcd_busy` = 1 in SHIFT and DONE.
  - A count change during a conversion is caught on the return to IDLE and reconverted. The final display always matches the final `count`.
- **HEX_MODE=1:** FSM is bypassed. `dig0` = `count[3:0]`, `dig1` = `count[7:4]`, updated the cycle after `count` changes. `bcd_busy` is tied to 0.
- **Blanking:**
  - Digit 3 is always blank.
  - HEX_MODE=1: digit 2 is blank.
  - HEX_MODE=0: digit 2 is blank when hundreds = 0; digit 1 is blank when hundreds = 0 and tens = 0.
  - Digit 0 is never blank.
  - A blank digit drives its anode 1, so all four anodes read 1111 during that slot.
- **Refresh:**
  - `rcnt` counts 0..REFRESH_DIV−1. At wrap, `sel` advances 0→1→2→3→0.
  - `an` = ~(1<<`sel`) unless the digit is blank.
  - `seg` = decode of the digit for `sel`.
  - `an`/`seg` are registered, updating one cycle after `sel` or the digit registers change.
- **Decode (active-low):** 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110.

## Timing
- **Reset values:** `count`=0, `slow_q`=0, `src`=0, digits=0, FSM=IDLE, `bcd_busy`=0, `rcnt`=0, `sel`=0, `an`=1110, `seg`=1000000, `dp`=1.
  - Display shows "0" immediately; no conversion runs after reset.
- **Reset mid-conversion:** aborts to the reset values above; no partial digits are committed.
- **Count latency:** `count` updates on the first `clk` edge that samples `slow_clk`=1 (same edge where `slow_q` rises).
- **Conversion latency (HEX_MODE=0):**
  - Edge N: `count` changes.
  - Edge N+1: load.
  - Edges N+2..N+9: 8 shifts.
  - Edge N+10: DONE commits digits.
  - Edge N+11: `an`/`seg` reflect the new digits if that digit is selected.
- **Tick spacing:** ticks are at least 2 cycles apart. Back-to-back changes extend `bcd_busy` but are never lost.
- **Refresh period:** each digit slot lasts exactly REFRESH_DIV cycles; the full frame is 4×REFRESH_DIV.

## Test plan
- **Reset:** assert `rst` mid-conversion (`count`=200) → next cycle `count`=0, `an`=1110, `seg`=1000000, `bcd_busy`=0, `dp`=1.
- **Count up:** 5 ticks, `en`=1, `up`=1 → `count`=5. Within 11 cycles, digit 0 shows 0010010 and slots 1–3 read `an`=1111.
- **Wrap and hold:**
  - From 255, one up tick → 0.
  - From 0, one down tick → 255; display slots show 5, 5, 2, blank.
  - `slow_clk` held high for 10 cycles → exactly one increment.
- **Enable gating:** `en`=0 with 3 ticks → `count` unchanged, `bcd_busy` stays 0.
- **Refresh order:** REFRESH_DIV=4, `count`=123 → `an` sequence 1110/1101/1011/1111, each held 4 cycles, with `seg` 0110000, 0100100, 1111001, don't-care.
- **Hex mode:** HEX_MODE=1, `count`=0xAB → digit 0 = 0000011, digit 1 = 0001000, digits 2–3 blank, `bcd_busy` never asserts.
